icache_fetch: RTL and testbench

Instruction-fetch stage with a direct-mapped, one-word-per-line instruction cache. It sits between the memory controller's instruction port and the decode/issue stage. It holds the PC and serves hits at one instruction per cycle. On a miss it issues a single 4-byte fetch to the memory controller, fills the line, and resumes; ROB redirects replace the PC at any time.

---
 rtl/icache_fetch.sv | 127 ++++++++++++
 tb/tb_icache_fetch.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch.sv
// ---------------------------------------------------------------------------
// Module   : icache_fetch
// Purpose  : Instruction-fetch stage with a direct-mapped, one-word-per-line
//            instruction cache; serves hits at 1/cycle, refills on miss.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module icache_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          INDEX_W  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        oMC_en,
    output logic [31:0] oMC_addr,
    input  logic        iMC_done,
    input  logic [31:0] iMC_inst,
    input  logic        iIF_stall,
    output logic        oIF_valid,
    output logic [31:0] oIF_inst,
    output logic [31:0] oIF_pc,
    input  logic        iJUMP_en,
    input  logic [31:0] iJUMP_pc
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 30 - INDEX_W;

    localparam logic [0:0] S_FETCH = 1'b0;
    localparam logic [0:0] S_MISS  = 1'b1;

    logic [0:0]        r_state;
    logic [31:0]       r_pc;
    logic              r_drop;
    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [31:0]       r_data [LINES];

    logic              r_mc_en;
    logic [31:0]       r_mc_addr;
    logic              r_if_valid;
    logic [31:0]       r_if_inst;
    logic [31:0]       r_if_pc;

    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit;
    logic [INDEX_W-1:0] w_fill_idx;
    logic               w_fill;

    assign w_index    = r_pc[INDEX_W+1:2];
    assign w_tag      = r_pc[31:INDEX_W+2];
    assign w_hit      = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_fill_idx = r_mc_addr[INDEX_W+1:2];
    assign w_fill     = rdy && (r_state == S_MISS) && iMC_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_drop     <= 1'b0;
            r_valid    <= '0;
            r_mc_en    <= 1'b0;
            r_mc_addr  <= 32'h0;
            r_if_valid <= 1'b0;
            r_if_inst  <= 32'h0;
            r_if_pc    <= 32'h0;
        end else if (rdy) begin
            r_if_valid <= 1'b0;
            if (r_state == S_FETCH) begin
                if (iJUMP_en) begin
                    r_pc <= iJUMP_pc;
                end else if (w_hit) begin
                    if (!iIF_stall) begin
                        r_if_valid <= 1'b1;
                        r_if_inst  <= r_data[w_index];
                        r_if_pc    <= r_pc;
                        r_pc       <= r_pc + 32'd4;
                    end
                end else begin
                    r_mc_en   <= 1'b1;
                    r_mc_addr <= r_pc;
                    r_drop    <= 1'b0;
                    r_state   <= S_MISS;
                end
            end else begin
                // The controller cannot abort, so a redirect only marks the
                // outstanding word as dropped; the request stays up until done.
                if (iMC_done) begin
                    r_valid[w_fill_idx] <= 1'b1;
                    r_mc_en             <= 1'b0;
                    r_state             <= S_FETCH;
                    if (iJUMP_en) begin
                        r_pc <= iJUMP_pc;
                    end else if (!r_drop && !iIF_stall) begin
                        r_if_valid <= 1'b1;
                        r_if_inst  <= iMC_inst;
                        r_if_pc    <= r_pc;
                        r_pc       <= r_pc + 32'd4;
                    end
                end else if (iJUMP_en) begin
                    r_pc   <= iJUMP_pc;
                    r_drop <= 1'b1;
                end
            end
        end
    end

    // Tag/data arrays carry no reset; the valid flops gate their contents.
    always_ff @(posedge clk) begin
        if (w_fill && !rst) begin
            r_tag[w_fill_idx]  <= r_mc_addr[31:INDEX_W+2];
            r_data[w_fill_idx] <= iMC_inst;
        end
    end

    assign oMC_en    = r_mc_en;
    assign oMC_addr  = r_mc_addr;
    assign oIF_valid = r_if_valid;
    assign oIF_inst  = r_if_inst;
    assign oIF_pc    = r_if_pc;

endmodule

`default_nettype wire

// File: tb/tb_icache_fetch.sv
// ---------------------------------------------------------------------------
// Module   : tb_icache_fetch
// Purpose  : Directed self-checking bench for icache_fetch.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_icache_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        oMC_en;
    logic [31:0] oMC_addr;
    logic        iMC_done = 1'b0;
    logic [31:0] iMC_inst = 32'h0;
    logic        iIF_stall = 1'b0;
    logic        oIF_valid;
    logic [31:0] oIF_inst;
    logic [31:0] oIF_pc;
    logic        iJUMP_en = 1'b0;
    logic [31:0] iJUMP_pc = 32'h0;

    int checks = 0;
    int errors = 0;

    icache_fetch #(.RESET_PC(32'h0), .INDEX_W(8)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .oMC_en(oMC_en), .oMC_addr(oMC_addr),
        .iMC_done(iMC_done), .iMC_inst(iMC_inst),
        .iIF_stall(iIF_stall),
        .oIF_valid(oIF_valid), .oIF_inst(oIF_inst), .oIF_pc(oIF_pc),
        .iJUMP_en(iJUMP_en), .iJUMP_pc(iJUMP_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a == 32'h0) ? 32'h00000013 : {16'hC0DE, a[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_emit(input string name, input logic [31:0] pc);
        checks++;
        if (oIF_valid !== 1'b1 || oIF_pc !== pc || oIF_inst !== mem(pc)) begin
            errors++;
            $display("FAIL %s: valid=%b pc=%h inst=%h, required valid=1 pc=%h inst=%h",
                     name, oIF_valid, oIF_pc, oIF_inst, pc, mem(pc));
        end
    endtask

    // Controller model: oMC_en is expected high on entry; lat cycles later done pulses.
    task automatic serve(input logic [31:0] addr, input int lat,
                         input logic jmp, input logic [31:0] jpc);
        int n = 0;
        while (oMC_en !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (oMC_en !== 1'b1 || oMC_addr !== addr) begin
            errors++;
            $display("FAIL serve_req: en=%b addr=%h, required en=1 addr=%h", oMC_en, oMC_addr, addr);
        end
        for (int i = 0; i < lat - 1; i++) begin
            tick();
            checks++;
            if (oMC_en !== 1'b1 || oMC_addr !== addr) begin
                errors++;
                $display("FAIL serve_hold: en=%b addr=%h, required en=1 addr=%h", oMC_en, oMC_addr, addr);
            end
        end
        iMC_done = 1'b1;
        iMC_inst = mem(addr);
        iJUMP_en = jmp;
        iJUMP_pc = jpc;
        tick();
        iMC_done = 1'b0;
        iJUMP_en = 1'b0;
        checks++;
        if (oMC_en !== 1'b0) begin
            errors++;
            $display("FAIL serve_drop_en: en=%b, required 0", oMC_en);
        end
    endtask

    task automatic jump_to(input logic [31:0] target);
        iJUMP_en = 1'b1;
        iJUMP_pc = target;
        tick();
        iJUMP_en = 1'b0;
        checks++;
        if (oIF_valid !== 1'b0) begin
            errors++;
            $display("FAIL jump_no_emit: valid=%b, required 0", oIF_valid);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (oMC_en !== 1'b0 || oMC_addr !== 32'h0 || oIF_valid !== 1'b0 ||
            oIF_inst !== 32'h0 || oIF_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: en=%b addr=%h valid=%b inst=%h pc=%h, required all 0",
                     oMC_en, oMC_addr, oIF_valid, oIF_inst, oIF_pc);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_cold_start();
        tick();
        serve(32'h0, 5, 1'b0, 32'h0);
        expect_emit("cold_emit", 32'h0);
        tick();
        checks++;
        if (oMC_en !== 1'b1 || oMC_addr !== 32'h4 || oIF_valid !== 1'b0) begin
            errors++;
            $display("FAIL cold_next_req: en=%b addr=%h valid=%b, required en=1 addr=4 valid=0",
                     oMC_en, oMC_addr, oIF_valid);
        end
        serve(32'h4, 2, 1'b0, 32'h0);
        expect_emit("fill_4", 32'h4);
        tick();
        serve(32'h8, 2, 1'b0, 32'h0);
        expect_emit("fill_8", 32'h8);
        tick();
        // Redirect coinciding with done: line 0xC filled but not emitted.
        serve(32'hC, 2, 1'b1, 32'h0);
        checks++;
        if (oIF_valid !== 1'b0) begin
            errors++;
            $display("FAIL jump_on_done: valid=%b, required 0", oIF_valid);
        end
    endtask

    task automatic test_loop_hits();
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_emit("loop_hit", 32'(i * 4));
            checks++;
            if (oMC_en !== 1'b0) begin
                errors++;
                $display("FAIL loop_no_req: en=%b, required 0", oMC_en);
            end
        end
        jump_to(32'h0);
    endtask

    task automatic test_stall();
        tick();
        expect_emit("pre_stall", 32'h0);
        iIF_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (oIF_valid !== 1'b0 || oMC_en !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: valid=%b en=%b, required valid=0 en=0", oIF_valid, oMC_en);
            end
        end
        iIF_stall = 1'b0;
        tick();
        expect_emit("post_stall", 32'h4);
    endtask

    task automatic test_redirect_in_miss();
        jump_to(32'h40);
        tick();
        checks++;
        if (oMC_en !== 1'b1 || oMC_addr !== 32'h40) begin
            errors++;
            $display("FAIL miss_40_req: en=%b addr=%h, required en=1 addr=40", oMC_en, oMC_addr);
        end
        iJUMP_en = 1'b1;
        iJUMP_pc = 32'h100;
        tick();
        iJUMP_en = 1'b0;
        serve(32'h40, 3, 1'b0, 32'h0);
        checks++;
        if (oIF_valid !== 1'b0) begin
            errors++;
            $display("FAIL dropped_emit: valid=%b, required 0", oIF_valid);
        end
        tick();
        serve(32'h100, 2, 1'b0, 32'h0);
        expect_emit("redirect_target", 32'h100);
        jump_to(32'h40);
        tick();
        expect_emit("dropped_line_hit", 32'h40);
        checks++;
        if (oMC_en !== 1'b0) begin
            errors++;
            $display("FAIL dropped_line_no_req: en=%b, required 0", oMC_en);
        end
    endtask

    task automatic test_alias();
        jump_to(32'h400);
        tick();
        serve(32'h400, 3, 1'b0, 32'h0);
        expect_emit("alias_400", 32'h400);
        jump_to(32'h0);
        tick();
        checks++;
        if (oMC_en !== 1'b1 || oMC_addr !== 32'h0 || oIF_valid !== 1'b0) begin
            errors++;
            $display("FAIL alias_evict: en=%b addr=%h valid=%b, required en=1 addr=0 valid=0",
                     oMC_en, oMC_addr, oIF_valid);
        end
        serve(32'h0, 2, 1'b0, 32'h0);
        expect_emit("alias_refill", 32'h0);
    endtask

    task automatic test_rdy();
        rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            expect_emit("rdy_hold", 32'h0);
        end
        rdy = 1'b1;
        tick();
        expect_emit("rdy_resume", 32'h4);
    endtask

    task automatic test_async_reset();
        jump_to(32'h200);
        tick();
        checks++;
        if (oMC_en !== 1'b1 || oMC_addr !== 32'h200) begin
            errors++;
            $display("FAIL pre_rst_req: en=%b addr=%h, required en=1 addr=200", oMC_en, oMC_addr);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (oMC_en !== 1'b0 || oMC_addr !== 32'h0 || oIF_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: en=%b addr=%h valid=%b, required all 0", oMC_en, oMC_addr, oIF_valid);
        end
        iMC_done = 1'b1;
        iMC_inst = mem(32'h200);
        tick();
        iMC_done = 1'b0;
        rst = 1'b0;
        tick();
        checks++;
        if (oMC_en !== 1'b1 || oMC_addr !== 32'h0) begin
            errors++;
            $display("FAIL restart_miss: en=%b addr=%h, required en=1 addr=0", oMC_en, oMC_addr);
        end
        serve(32'h0, 1, 1'b0, 32'h0);
        expect_emit("restart_emit", 32'h0);
        tick();
        checks++;
        if (oMC_en !== 1'b1 || oMC_addr !== 32'h4) begin
            errors++;
            $display("FAIL valid_cleared: en=%b addr=%h, required en=1 addr=4", oMC_en, oMC_addr);
        end
    endtask

    initial begin
        test_reset();
        test_cold_start();
        test_loop_hits();
        test_stall();
        test_redirect_in_miss();
        test_alias();
        test_rdy();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
